// File: rtl/ppfifo_axis_pkg.sv
// Shared definitions for the PPFIFO-to-AXI-stream reader.
// Holds the state encoding, the PPFIFO size width and the position of the
// packet-last flag inside a PPFIFO word.
package ppfifo_axis_pkg;

  localparam int unsigned PPF_SIZE_W = 24;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ACTIVE_ENC = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_ACTIVE = ST_ACTIVE_ENC,
    ST_DRAIN  = ST_DRAIN_ENC
  } state_e;

  // The packet-last flag sits just above the data field of a PPFIFO word.
  function automatic int unsigned last_bit_pos(input int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/ppfifo_rd_skid2.sv
// Two-entry output buffer between the PPFIFO read port and the AXI stream.
// Ports: clk/rst_n; i_push + i_word (data with packet last) + i_blk_last
// write side; o_occ occupancy; o_valid/i_ready/o_data/o_last AXI pop side.
module ppfifo_rd_skid2
  import ppfifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          BLOCK_LAST_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH:0]   i_word,
  input  logic                  i_blk_last,
  output logic [1:0]            o_occ,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  localparam int unsigned ENT_W   = DATA_WIDTH + 2;
  localparam int unsigned PKT_BIT = last_bit_pos(DATA_WIDTH);
  localparam int unsigned BLK_BIT = PKT_BIT + 1;

  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             pop;
  logic [1:0]       slot;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    pop     = valid_q & i_ready;
    slot    = occ_q - 2'(pop);
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (i_push) begin
      if (slot == 2'd0) begin
        ent0_d = {i_blk_last, i_word};
      end else begin
        ent1_d = {i_blk_last, i_word};
      end
    end
    occ_d   = occ_q + 2'(i_push) - 2'(pop);
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign o_occ   = occ_q;
  assign o_valid = valid_q;
  assign o_data  = ent0_q[DATA_WIDTH-1:0];
  assign o_last  = ent0_q[PKT_BIT] | (BLOCK_LAST_EN & ent0_q[BLK_BIT]);

endmodule

// File: rtl/adapter_ppfifo_2_axi_stream_wl.sv
// Reads filled Ping Pong FIFO blocks and replays them as an AXI stream.
// Ports: i_axi_clk/rst_n; PPFIFO read side (o_ppfifo_clk, i_ppfifo_rdy,
// o_ppfifo_act, i_ppfifo_size, o_ppfifo_stb, i_ppfifo_data); AXI stream
// master (o_axi_valid, i_axi_ready, o_axi_data, o_axi_keep, o_axi_last).
module adapter_ppfifo_2_axi_stream_wl
  import ppfifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned STROBE_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned LAST_ON_BLOCK_END = 0
) (
  input  logic                    i_axi_clk,
  input  logic                    rst_n,
  output logic                    o_ppfifo_clk,
  input  logic                    i_ppfifo_rdy,
  output logic                    o_ppfifo_act,
  input  logic [PPF_SIZE_W-1:0]   i_ppfifo_size,
  output logic                    o_ppfifo_stb,
  input  logic [DATA_WIDTH:0]     i_ppfifo_data,
  output logic                    o_axi_valid,
  input  logic                    i_axi_ready,
  output logic [DATA_WIDTH-1:0]   o_axi_data,
  output logic [STROBE_WIDTH-1:0] o_axi_keep,
  output logic                    o_axi_last
);

  state_e                state_q, state_d;
  logic                  act_q, act_d;
  logic                  stb_q, stb_d;
  logic                  stb_blk_last_q, stb_blk_last_d;
  logic                  pend_q, pend_d;
  logic                  pend_blk_last_q, pend_blk_last_d;
  logic [PPF_SIZE_W-1:0] size_q, size_d;
  logic [PPF_SIZE_W-1:0] count_q, count_d;
  logic [PPF_SIZE_W-1:0] count_nxt;
  logic [1:0]            occ;
  logic [2:0]            outstanding;
  logic                  xfer;
  logic                  credit;

  // Outstanding words = buffered + strobe on the port + word on the data bus.
  // A strobe is allowed only if the buffer can still absorb every one of them.
  always_comb begin
    state_d         = state_q;
    act_d           = act_q;
    stb_d           = 1'b0;
    stb_blk_last_d  = 1'b0;
    pend_d          = stb_q;
    pend_blk_last_d = stb_blk_last_q;
    size_d          = size_q;
    count_d         = count_q;
    count_nxt       = count_q + PPF_SIZE_W'(1);
    xfer            = o_axi_valid & i_axi_ready;
    outstanding     = 3'(occ) + 3'(stb_q) + 3'(pend_q);
    credit          = (outstanding < 3'd2) | ((outstanding == 3'd2) & xfer);

    case (state_q)
      ST_IDLE: begin
        if (i_ppfifo_rdy) begin
          act_d   = 1'b1;
          size_d  = i_ppfifo_size;
          count_d = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (count_q >= size_q) begin
          state_d = ST_DRAIN;
        end else if (credit) begin
          stb_d          = 1'b1;
          count_d        = count_nxt;
          stb_blk_last_d = (count_nxt == size_q);
          if (count_nxt == size_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Release the block only once every requested word has been captured.
        if (!stb_q && !pend_q) begin
          act_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        act_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      act_q           <= 1'b0;
      stb_q           <= 1'b0;
      stb_blk_last_q  <= 1'b0;
      pend_q          <= 1'b0;
      pend_blk_last_q <= 1'b0;
      size_q          <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      act_q           <= act_d;
      stb_q           <= stb_d;
      stb_blk_last_q  <= stb_blk_last_d;
      pend_q          <= pend_d;
      pend_blk_last_q <= pend_blk_last_d;
      size_q          <= size_d;
      count_q         <= count_d;
    end
  end

  // Words arrive one cycle after their strobe and are captured that cycle.
  ppfifo_rd_skid2 #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BLOCK_LAST_EN (LAST_ON_BLOCK_END != 0)
  ) u_skid (
    .clk        (i_axi_clk),
    .rst_n      (rst_n),
    .i_push     (pend_q),
    .i_word     (i_ppfifo_data),
    .i_blk_last (pend_blk_last_q),
    .o_occ      (occ),
    .o_valid    (o_axi_valid),
    .i_ready    (i_axi_ready),
    .o_data     (o_axi_data),
    .o_last     (o_axi_last)
  );

  assign o_ppfifo_clk = i_axi_clk;
  assign o_ppfifo_act = act_q;
  assign o_ppfifo_stb = stb_q;
  assign o_axi_keep   = {STROBE_WIDTH{1'b1}};

endmodule
